// File: rtl/reg_bank_pkg.sv
// Shared defaults and helpers for the register-bank write arbiter.
// Sizes the address and pointer widths and locates per-requester fields in flat buses.
package reg_bank_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREG_DEF = 4;
    localparam int unsigned W_DEF    = 8;

    // Width needed to index n entries; never narrower than one bit.
    function automatic int unsigned calc_aw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of requester i's field in a flat bus of w-bit fields.
    function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
        return i * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_masked at or above ptr, wrapping.
// Duplicating the request vector turns the wrap into a plain lowest-bit search.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = calc_aw(N)
) (
    input  logic [N-1:0]  req_masked,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          win_valid
);

    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_mask;
    logic [2*N-1:0] dbl_hit;

    always_comb begin
        dbl_req  = {req_masked, req_masked};
        dbl_mask = '0;
        for (int j = 0; j < 2 * N; j++) begin
            dbl_mask[j] = (j >= int'(ptr));
        end
        dbl_hit   = dbl_req & dbl_mask;
        win       = '0;
        win_valid = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (dbl_hit[j] && !win_valid) begin
                win_valid   = 1'b1;
                win[j % N]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Register bank with one round-robin arbitrated write port and a combinational read port.
// A requester is masked while its gnt is high so a held req is not written twice.
module reg_bank_wr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned W    = W_DEF,
    localparam int unsigned AW  = calc_aw(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*W-1:0] wr_data,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    input  logic [AW-1:0]     rd_addr,
    output logic [W-1:0]      rd_data
);

    localparam int unsigned PW = calc_aw(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    regs_q [NREG];
    logic [W-1:0]    regs_d [NREG];

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] win;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   sel_addr;
    logic [W-1:0]    sel_data;

    assign eligible = req & ~gnt_q;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req_masked (eligible),
        .ptr        (ptr_q),
        .win        (win),
        .win_valid  (win_valid)
    );

    always_comb begin
        win_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                sel_addr = wr_addr[slice_lo(i, AW) +: AW];
                sel_data = wr_data[slice_lo(i, W) +: W];
            end
        end
    end

    always_comb begin
        gnt_d  = win;
        busy_d = win_valid;
        ptr_d  = ptr_q;
        regs_d = regs_q;
        if (win_valid) begin
            ptr_d            = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            regs_d[sel_addr] = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            regs_q <= '{default: '0};
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
            regs_q <= regs_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign rd_data = regs_q[rd_addr];

endmodule
